// File: rtl/order_queue_ctrl.sv
// In-order tag queue controller driving an external synchronous-read memory.
// Tracks head/tail/occupancy and masks the head while a same-entry write/read collision is in flight.
module order_queue_ctrl #(
    parameter int WIDTH        = 5,
    parameter int DEPTH        = 32,
    parameter int ADDRESSWIDTH = 6,
    parameter int PTRWIDTH     = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_tag,
    input  logic                    pop,
    output logic                    mem_we,
    output logic [ADDRESSWIDTH-1:0] mem_dest,
    output logic [ADDRESSWIDTH-1:0] mem_source,
    output logic [WIDTH-1:0]        mem_dataIn,
    input  logic [WIDTH-1:0]        mem_dataOut,
    output logic [WIDTH-1:0]        head_tag,
    output logic                    head_valid,
    output logic                    full,
    output logic                    empty,
    output logic [PTRWIDTH:0]       count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam logic [PTRWIDTH:0] DEPTHCOUNT = (PTRWIDTH+1)'(DEPTH);

    logic [PTRWIDTH-1:0] headPtr;
    logic [PTRWIDTH-1:0] tailPtr;
    logic [PTRWIDTH-1:0] headNext;
    logic [PTRWIDTH:0]   countAfterPop;
    logic                stale;
    logic                pushAcc;
    logic                popAcc;

    assign full       = (count == DEPTHCOUNT);
    assign empty      = (count == '0);
    assign head_valid = (count != '0) && !stale;

    assign pushAcc = push && !full && !flush && !reset;
    assign popAcc  = pop && head_valid && !flush && !reset;

    // Read address runs one entry ahead on a pop so the new head is on mem_dataOut next cycle.
    assign headNext      = headPtr + PTRWIDTH'(popAcc);
    assign countAfterPop = count - (PTRWIDTH+1)'(popAcc);

    assign mem_we     = pushAcc;
    assign mem_dest   = ADDRESSWIDTH'(tailPtr);
    assign mem_dataIn = push_tag;
    assign mem_source = ADDRESSWIDTH'(headNext);
    assign head_tag   = mem_dataOut;

    always_ff @(posedge clock) begin
        if (reset) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
            stale   <= 1'b0;
        end else if (flush) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
            stale   <= 1'b0;
        end else begin
            if (pushAcc) begin
                tailPtr <= tailPtr + PTRWIDTH'(1);
            end
            headPtr <= headNext;
            count   <= countAfterPop + (PTRWIDTH+1)'(pushAcc);
            // Writing the entry being read this edge: memory hands back the old contents.
            stale   <= pushAcc && (countAfterPop == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full && !flush) begin
                overflow <= 1'b1;
            end
            if (pop && !head_valid && !flush) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_order_queue_ctrl.sv
// Randomized and directed bench for order_queue_ctrl with a queue-based reference model
// and a behavioural synchronous-read memory attached to the controller.
module tb_order_queue_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       push = 1'b0;
    logic [4:0] push_tag = '0;
    logic       pop = 1'b0;
    logic       mem_we;
    logic [5:0] mem_dest;
    logic [5:0] mem_source;
    logic [4:0] mem_dataIn;
    logic [4:0] mem_dataOut;
    logic [4:0] head_tag;
    logic       head_valid;
    logic       full;
    logic       empty;
    logic [5:0] count;
    logic       overflow;
    logic       underflow;

    order_queue_ctrl dut (
        .clock(clock), .reset(reset), .flush(flush), .push(push), .push_tag(push_tag),
        .pop(pop), .mem_we(mem_we), .mem_dest(mem_dest), .mem_source(mem_source),
        .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut), .head_tag(head_tag),
        .head_valid(head_valid), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    // Synchronous-read memory: read-before-write on a same-address collision.
    logic [4:0] memArr [64];
    always @(posedge clock) begin
        if (reset) mem_dataOut <= '0;
        else       mem_dataOut <= memArr[mem_source];
        if (mem_we) memArr[mem_dest] <= mem_dataIn;
    end

    // Reference model: queue of tags, each stamped with the edge at which it was written.
    typedef struct {
        logic [4:0] tag;
        int         wEdge;
    } entry_t;

    entry_t q[$];
    int     edgeNum = 0;
    int     expHead = 0;
    int     expTail = 0;
    logic   expOvf = 1'b0;
    logic   expUnf = 1'b0;
    int     passCount = 0;
    int     checkCount = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic modelClear(input logic clrSticky);
        q.delete();
        expHead = 0;
        expTail = 0;
        if (clrSticky) begin
            expOvf = 1'b0;
            expUnf = 1'b0;
        end
    endtask

    task automatic step(input logic p, input logic [4:0] t, input logic po, input logic fl, input logic rs);
        logic expHV, expFull, pa, pp;
        push = p; push_tag = t; pop = po; flush = fl; reset = rs;
        @(negedge clock);
        // A head written at the immediately preceding edge has not reached the read port yet.
        expHV   = (q.size() > 0) && (q[0].wEdge != edgeNum);
        expFull = (q.size() == 32);
        pa = p && !expFull && !fl && !rs;
        pp = po && expHV && !fl && !rs;
        chk("count", 32'(count), 32'(q.size()));
        chk("full", 32'(full), 32'(expFull));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("head_valid", 32'(head_valid), 32'(expHV));
        if (expHV) chk("head_tag", 32'(head_tag), 32'(q[0].tag));
        chk("mem_we", 32'(mem_we), 32'(pa));
        if (pa) begin
            chk("mem_dest", 32'(mem_dest), 32'(expTail));
            chk("mem_dataIn", 32'(mem_dataIn), 32'(t));
        end
        chk("mem_source", 32'(mem_source), 32'((expHead + (pp ? 1 : 0)) % 32));
        chk("overflow", 32'(overflow), 32'(expOvf));
        chk("underflow", 32'(underflow), 32'(expUnf));
        @(posedge clock);
        edgeNum++;
        if (rs) begin
            modelClear(1'b1);
        end else begin
            if (p && expFull && !fl) expOvf = 1'b1;
            if (po && !expHV && !fl) expUnf = 1'b1;
            if (fl) begin
                modelClear(1'b0);
            end else begin
                if (pp) begin
                    void'(q.pop_front());
                    expHead = (expHead + 1) % 32;
                end
                if (pa) begin
                    q.push_back('{tag: t, wEdge: edgeNum});
                    expTail = (expTail + 1) % 32;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        step(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int pushed;
        int guard;
        logic p, po;
        for (int i = 0; i < 64; i++) memArr[i] = '0;

        // Power-up: registers are unknown until the first reset edge.
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        modelClear(1'b1);
        doReset();

        // Single push into an empty queue: head visible two cycles later.
        step(1'b1, 5'h03, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("first_push_tag", 32'(head_tag), 32'h03);

        // Fill to full, then a rejected push with pop also requested.
        doReset();
        for (int i = 0; i < 32; i++) step(1'b1, 5'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'h1F, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("overflow_set", 32'(overflow), 32'd1);

        // Drain with pop held, then one pop too many.
        for (int i = 0; i < 31; i++) step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("underflow_set", 32'(underflow), 32'd1);
        chk("drained_empty", 32'(empty), 32'd1);

        // Wrap: 40 tags through a shallow window.
        doReset();
        pushed = 0;
        guard = 0;
        while ((pushed < 40 || q.size() != 0) && guard < 400) begin
            p  = (pushed < 40) && (q.size() < 4) && ($urandom_range(0, 3) != 0);
            po = ($urandom_range(0, 1) == 1);
            step(p, 5'(pushed + 7), po, 1'b0, 1'b0);
            if (p) pushed++;
            guard++;
        end
        chk("wrap_done", 32'(guard < 400), 32'd1);
        chk("wrap_tail", 32'(expTail), 32'd8);

        // Push and pop together at count 1.
        doReset();
        step(1'b1, 5'h05, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 5'h1A, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("collide_tag", 32'(head_tag), 32'h1A);

        // Flush overrides push and pop at count 10; sticky flags survive.
        doReset();
        step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 5'(i + 3), 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 5'h11, 1'b1, 1'b1, 1'b0);
        idle(3);
        chk("flush_underflow_kept", 32'(underflow), 32'd1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) < 6, 5'($urandom), $urandom_range(0, 9) < 5,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 1);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/order_queue_ctrl.md
ORDER_QUEUE_CTRL -- requirements
Module: order_queue_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, 5, tag width; DEPTH, 32, entries (power of two); ADDRESSWIDTH, 6, memory address width; PTRWIDTH, 5, log2(DEPTH).
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; reset is reset, clock is clock.
REQ-004 flush  input  1  discards all queued tags (mispredict recovery).
REQ-005 push  input  1  dispatch request to enqueue push_tag.
REQ-006 push_tag  input  WIDTH  tag enqueued in program order.
REQ-007 pop  input  1  commit request to dequeue head entry.
REQ-008 mem_we  output  1  write enable to the order-queue memory.
REQ-009 mem_dest  output  ADDRESSWIDTH  memory write address.
REQ-010 mem_source  output  ADDRESSWIDTH  memory read address.
REQ-011 mem_dataIn  output  WIDTH  memory write data.
REQ-012 mem_dataOut  input  WIDTH  registered memory read data (1-cycle latency, reset to 0).
REQ-013 head_tag  output  WIDTH  oldest queued tag; equals mem_dataOut.
REQ-014 head_valid  output  1  head_tag is valid and may be popped.
REQ-015 full, empty  output  1 each  occupancy flags.
REQ-016 count  output  PTRWIDTH+1  occupancy, 0..DEPTH.
REQ-017 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-018 State SHALL be head_ptr, tail_ptr (PTRWIDTH bits, wrap DEPTH-1 -> 0), count, stale bit, overflow, underflow.
REQ-019 full SHALL equal (count == DEPTH); empty SHALL equal (count == 0); both combinational from count.
REQ-020 push_acc SHALL equal push && !full && !flush, using full before any same-cycle pop (push while full is rejected even with pop).
REQ-021 pop_acc SHALL equal pop && head_valid && !flush.
REQ-022 mem_we SHALL equal push_acc; mem_dest SHALL equal {0, tail_ptr}; mem_dataIn SHALL equal push_tag; all combinational.
REQ-023 On push_acc tail_ptr SHALL increment modulo DEPTH at the clock edge.
REQ-024 On pop_acc head_ptr SHALL increment modulo DEPTH at the clock edge.
REQ-025 count SHALL change by +1 (push_acc only), -1 (pop_acc only), 0 (both or neither).
REQ-026 mem_source SHALL be {0, head_next} combinationally, head_next = head_ptr+1 on pop_acc else head_ptr, so mem_dataOut holds the new head the cycle after a pop.
REQ-027 stale SHALL be set at an edge where push_acc occurs and count after pop is 0 (write and read of same entry collide; memory returns old data), otherwise cleared.
REQ-028 head_valid SHALL equal (count != 0) && !stale; a first push into an empty queue yields head_valid two cycles after the push cycle.
REQ-029 Simultaneous push_acc and pop_acc with count==1 SHALL set stale (new head is the entry being written).
REQ-030 flush SHALL have priority over push and pop: at the edge, head_ptr, tail_ptr, count, stale SHALL clear to 0; memory contents are not cleared; mem_we SHALL be 0 in the flush cycle.
REQ-031 overflow SHALL set when push && full && !flush; underflow SHALL set when pop && !head_valid && !flush; both held until reset (not cleared by flush).
REQ-032 head_tag SHALL be valid only while head_valid; consumers ignore it otherwise.

Reset
REQ-033 While reset is high at a clock edge, head_ptr, tail_ptr, count, stale, overflow, underflow SHALL clear to 0, giving empty=1, full=0, head_valid=0, count=0.
REQ-034 During reset cycles mem_we SHALL be 0 and push/pop SHALL be ignored; reset mid-operation discards all entries.
REQ-035 Reset SHALL have priority over flush.

Verification
REQ-036 Reset, push 0x03 one cycle -> mem_we=1, mem_dest=0; head_valid=0 next cycle, =1 cycle after, head_tag=0x03, count=1.
REQ-037 Push tags 0..31 back-to-back -> full=1, count=32 after 32nd edge; 33rd push -> no mem_we, overflow=1, count stays 32.
REQ-038 Pop all 32 -> head_tag sequence 0..31 one per cycle with pop held, empty=1 at end; extra pop -> underflow=1, head_ptr unchanged.
REQ-039 Wrap: push 40 / pop 40 interleaved keeping count<=4 -> tags emerge in order, mem_dest wraps 31->0.
REQ-040 count==1, push 0x1A and pop same cycle -> count=1, head_valid=0 one cycle, then head_tag=0x1A.
REQ-041 count=10 with push and pop asserted, flush=1 -> mem_we=0, next cycle count=0, empty=1, head_valid=0, overflow/underflow unchanged.
